// File: rtl/camera_telemetry_tx.sv
// camera_telemetry_tx
// Streams an atomic snapshot of the camera pose onto a UART line as one
// byte-framed packet: header 0xA5, then pos.x, pos.y, pos.z, dir.x, dir.y,
// dir.z (each zero-extended to NB bytes, MSB byte first), then the XOR of all
// field bytes. Frames go out on request or periodically while enabled; a
// trigger that arrives mid-frame is remembered once and coalesced.
//
// Ports:
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   enable_in        enables periodic frames every PERIOD_MS
//   send_req_in      single-cycle request for one frame
//   pos_in, dir_in   camera vectors; element 0 = x, 1 = y, 2 = z
//   uart_tx_out      registered UART line, idle high, 8N1, LSB first
//   busy_out         high from frame start to the end of the last stop bit
//   frames_sent_out  count of completed frames, wraps at 16 bits

`ifndef FP_BITS
`define FP_BITS 32
`endif

module camera_telemetry_tx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int FP_BITS   = `FP_BITS,
  parameter int PERIOD_MS = 50
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    enable_in,
  input  logic                    send_req_in,
  input  logic [2:0][FP_BITS-1:0] pos_in,
  input  logic [2:0][FP_BITS-1:0] dir_in,
  output logic                    uart_tx_out,
  output logic                    busy_out,
  output logic [15:0]             frames_sent_out
);

  localparam int BAUD_DIV      = CLK_HZ / BAUD;
  localparam int NB            = (FP_BITS + 7) / 8;
  localparam int FIELD_W       = NB * 8;
  localparam int SHADOW_W      = 6 * FIELD_W;
  localparam int FRAME_BYTES   = 2 + 6 * NB;
  localparam int PERIOD_CYC    = PERIOD_MS * (CLK_HZ / 1000);

  localparam int BAUD_W        = $clog2(BAUD_DIV + 1);
  localparam int IDX_W         = $clog2(FRAME_BYTES + 1);
  localparam int PER_W         = $clog2(PERIOD_CYC + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
  localparam logic [7:0]        HEADER    = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [IDX_W-1:0]    byte_idx;
  logic [SHADOW_W-1:0] shadow, snap;
  logic [7:0]          csum, cur_byte;
  logic [PER_W-1:0]    period_cnt;
  logic [15:0]         frames;
  logic                pending, trig_q, tx, tx_n;
  logic                tick, bit_done, last_byte, field_byte;
  logic                frame_done, launch;

  // Periodic trigger: counter only runs while enabled.
  assign tick       = enable_in && (period_cnt == PER_LAST);

  assign bit_done   = (baud_cnt == BAUD_LAST);
  assign last_byte  = (byte_idx == IDX_LAST);
  assign field_byte = (byte_idx != '0) && !last_byte;
  assign frame_done = (state == STOP) && bit_done && last_byte;
  // A new frame begins from IDLE, or straight out of the last stop bit when a
  // trigger is pending or arrives on that very cycle.
  assign launch     = ((state == IDLE) && trig_q) || (frame_done && (pending || trig_q));

  // Shadow layout: pos.x occupies the top field so bytes leave from the MSB end.
  always_comb begin
    snap = '0;
    for (int f = 0; f < 3; f++) begin
      snap[(5 - f) * FIELD_W +: FIELD_W] = FIELD_W'(pos_in[f]);
      snap[(2 - f) * FIELD_W +: FIELD_W] = FIELD_W'(dir_in[f]);
    end
  end

  always_comb begin
    if (byte_idx == '0)  cur_byte = HEADER;
    else if (last_byte)  cur_byte = csum;
    else                 cur_byte = shadow[SHADOW_W-1 -: 8];
  end

  // NOTE: defaults are assigned first so no path through this block infers a latch.
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    tx_n      = 1'b1;
    unique case (state)
      IDLE:  if (trig_q) state_n = START;
      START: if (bit_done) state_n = DATA;
      DATA:  if (bit_done && bit_idx == 3'd7) state_n = STOP;
      STOP:  if (bit_done) state_n = (!last_byte || pending || trig_q) ? START : IDLE;
      default: state_n = IDLE;
    endcase

    if (state == START)                 bit_idx_n = 3'd0;
    else if (state == DATA && bit_done) bit_idx_n = bit_idx + 3'd1;

    // Line level is decided from the next state so the pin itself is a flop.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      // NOTE: the shadow buffer is plain flops rather than RAM, so it is reset like the rest.
      shadow     <= '0;
      csum       <= '0;
      pending    <= 1'b0;
      period_cnt <= '0;
      trig_q     <= 1'b0;
      tx         <= 1'b1;
      frames     <= '0;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
      // Registering the trigger gives the fixed one-cycle start latency.
      trig_q  <= send_req_in | tick;

      // Every state exit happens on bit_done, so this restarts the divider on entry.
      baud_cnt <= (state == IDLE || bit_done) ? '0 : baud_cnt + 1'b1;

      if (!enable_in || tick) period_cnt <= '0;
      else                    period_cnt <= period_cnt + 1'b1;

      if (state == STOP && bit_done) begin
        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        if (field_byte) begin
          csum   <= csum ^ shadow[SHADOW_W-1 -: 8];
          shadow <= shadow << 8;
        end
      end

      if (frame_done) frames <= frames + 16'd1;

      if (launch) begin
        shadow   <= snap;
        csum     <= '0;
        byte_idx <= '0;
        pending  <= 1'b0;
      end else if (trig_q && state != IDLE) begin
        pending  <= 1'b1;
      end
    end
  end

  assign uart_tx_out     = tx;
  assign busy_out        = (state != IDLE);
  assign frames_sent_out = frames;

endmodule
